// File: rtl/gray_position_tracker_pkg.sv
// -----------------------------------------------------------------------------
// gray_position_tracker_pkg
//   Shared definitions for the 2-bit Gray position tracker:
//     - state_e      : tracker FSM state encoding
//     - step_kind_e  : classification of the binary difference between the new
//                      sample and the previous one (modulo 4)
//     - gray2bin     : 2-bit Gray-to-binary mapping (00=0, 01=1, 11=2, 10=3)
// -----------------------------------------------------------------------------
package gray_position_tracker_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    // Encoded so the value equals (new_bin - prev_bin) mod 4; a cast from the
    // raw difference gives the step kind directly.
    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_UP      = 2'd1,
        STEP_ILLEGAL = 2'd2,
        STEP_DOWN    = 2'd3
    } step_kind_e;

    function automatic logic [1:0] gray2bin(input logic [1:0] gray);
        return {gray[1], gray[1] ^ gray[0]};
    endfunction

endpackage

// File: rtl/gray_position_tracker_gray2bin_2bit.sv
// -----------------------------------------------------------------------------
// gray2bin_2bit
//   Purely combinational 2-bit Gray-to-binary converter.
//   Ports:
//     gray_i  [1:0]  Gray-coded input
//     bin_o   [1:0]  binary equivalent (00=0, 01=1, 11=2, 10=3)
// -----------------------------------------------------------------------------
module gray2bin_2bit
    import gray_position_tracker_pkg::*;
(
    input  logic [1:0] gray_i,
    output logic [1:0] bin_o
);

    assign bin_o = gray2bin(gray_i);

endmodule

// File: rtl/gray_position_tracker.sv
// -----------------------------------------------------------------------------
// gray_position_tracker
//   Follows a 2-bit Gray counter and accumulates an up/down position. Each
//   qualified sample is compared against the previously accepted sample:
//   +1 in Gray order steps up, -1 steps down, no change is ignored, and a jump
//   of two (both bits flipped) is illegal and parks the block in FAULT until
//   clr_err is pulsed. All outputs are registered.
//   Ports:
//     clk      clock, rising edge
//     rst      asynchronous reset, active low
//     en       sample qualifier for gray_in
//     gray_in  [1:0]        Gray sample from upstream counter
//     clr_err  leave FAULT (ignored in other states)
//     bin_out  [1:0]        binary value of last accepted sample
//     pos      [POS_W-1:0]  position accumulator, wraps modulo 2^POS_W
//     dir      direction of last step (1=up, 0=down)
//     step     one-cycle pulse per accepted step
//     err      high while in FAULT
// -----------------------------------------------------------------------------
module gray_position_tracker
    import gray_position_tracker_pkg::*;
#(
    parameter int unsigned POS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       gray_in,
    input  logic             clr_err,
    output logic [1:0]       bin_out,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             err
);

    state_e           state_q, state_d;
    logic [1:0]       prev_q,  prev_d;
    logic [1:0]       bin_q,   bin_d;
    logic [POS_W-1:0] pos_q,   pos_d;
    logic             dir_q,   dir_d;
    logic             step_q,  step_d;
    logic             err_q,   err_d;

    logic [1:0]  sample_bin;
    logic [1:0]  prev_bin;
    step_kind_e  step_kind;

    gray2bin_2bit u_gray2bin (
        .gray_i (gray_in),
        .bin_o  (sample_bin)
    );

    assign prev_bin  = gray2bin(prev_q);
    assign step_kind = step_kind_e'(sample_bin - prev_bin);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        bin_d   = bin_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                if (en) begin
                    prev_d  = gray_in;
                    bin_d   = sample_bin;
                    state_d = ST_TRACK;
                end
            end

            ST_TRACK: begin
                if (en) begin
                    unique case (step_kind)
                        STEP_NONE: ;
                        STEP_UP: begin
                            pos_d  = pos_q + POS_W'(1);
                            dir_d  = 1'b1;
                            step_d = 1'b1;
                            prev_d = gray_in;
                            bin_d  = sample_bin;
                        end
                        STEP_DOWN: begin
                            pos_d  = pos_q - POS_W'(1);
                            dir_d  = 1'b0;
                            step_d = 1'b1;
                            prev_d = gray_in;
                            bin_d  = sample_bin;
                        end
                        STEP_ILLEGAL: state_d = ST_FAULT;
                        default: ;
                    endcase
                end
            end

            ST_FAULT: begin
                // Samples are dropped here even when clr_err and en coincide;
                // INIT re-captures a fresh reference on the next qualified sample.
                if (clr_err) begin
                    state_d = ST_INIT;
                end
            end

            default: state_d = ST_INIT;
        endcase

        // err is registered from the next state so it rises with FAULT entry.
        err_d = (state_d == ST_FAULT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            prev_q  <= 2'b00;
            bin_q   <= 2'b00;
            pos_q   <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            bin_q   <= bin_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign bin_out = bin_q;
    assign pos     = pos_q;
    assign dir     = dir_q;
    assign step    = step_q;
    assign err     = err_q;

endmodule

// File: tb/tb_gray_position_tracker.sv
// -----------------------------------------------------------------------------
// tb_gray_position_tracker
//   Directed bench for gray_position_tracker (POS_W=8). Inputs change on the
//   falling edge; outputs are checked on the following falling edge, i.e. one
//   rising edge after the sample was presented.
// -----------------------------------------------------------------------------
module tb_gray_position_tracker;

    localparam int unsigned POS_W = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       gray_in;
    logic             clr_err;
    logic [1:0]       bin_out;
    logic [POS_W-1:0] pos;
    logic             dir;
    logic             step;
    logic             err;

    int vectors;
    int miscompares;

    gray_position_tracker #(.POS_W(POS_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .gray_in (gray_in),
        .clr_err (clr_err),
        .bin_out (bin_out),
        .pos     (pos),
        .dir     (dir),
        .step    (step),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Checks the full output set against hand-computed values.
    task automatic expect_out(input string tag, input int b, input int p,
                              input int d, input int s, input int e);
        check({tag, ".bin_out"}, 32'(bin_out), 32'(b));
        check({tag, ".pos"},     32'(pos),     32'(p));
        check({tag, ".dir"},     32'(dir),     32'(d));
        check({tag, ".step"},    32'(step),    32'(s));
        check({tag, ".err"},     32'(err),     32'(e));
    endtask

    // Present one set of inputs for exactly one rising edge.
    task automatic cyc(input logic e, input logic [1:0] g, input logic c);
        en      = e;
        gray_in = g;
        clr_err = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b0;
        en      = 1'b0;
        gray_in = 2'b00;
        clr_err = 1'b0;

        #12;
        expect_out("reset", 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // Upward count from INIT: first sample only captures the reference.
        cyc(1'b1, 2'b00, 1'b0); expect_out("up0", 0, 0, 1, 0, 0);
        cyc(1'b1, 2'b01, 1'b0); expect_out("up1", 1, 1, 1, 1, 0);
        cyc(1'b1, 2'b11, 1'b0); expect_out("up2", 2, 2, 1, 1, 0);
        cyc(1'b1, 2'b10, 1'b0); expect_out("up3", 3, 3, 1, 1, 0);
        cyc(1'b1, 2'b00, 1'b0); expect_out("up4", 0, 4, 1, 1, 0);

        // Downward count.
        cyc(1'b1, 2'b10, 1'b0); expect_out("dn3", 3, 3, 0, 1, 0);
        cyc(1'b1, 2'b11, 1'b0); expect_out("dn2", 2, 2, 0, 1, 0);
        cyc(1'b1, 2'b01, 1'b0); expect_out("dn1", 1, 1, 0, 1, 0);

        // Upstream holding still: no steps, position constant.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 2'b01, 1'b0);
            expect_out("hold", 1, 1, 0, 0, 0);
        end

        // Qualifier low while the code moves: nothing updates.
        cyc(1'b0, 2'b11, 1'b0); expect_out("en_low", 1, 1, 0, 0, 0);
        cyc(1'b1, 2'b11, 1'b0); expect_out("after_en", 2, 2, 1, 1, 0);

        // Move to prev=00 at pos 4, then jump illegally to 11.
        cyc(1'b1, 2'b10, 1'b0); expect_out("pre_f3", 3, 3, 1, 1, 0);
        cyc(1'b1, 2'b00, 1'b0); expect_out("pre_f4", 0, 4, 1, 1, 0);
        cyc(1'b1, 2'b11, 1'b0); expect_out("illegal", 0, 4, 1, 0, 1);
        cyc(1'b1, 2'b01, 1'b0); expect_out("fault_ign", 0, 4, 1, 0, 1);
        cyc(1'b1, 2'b01, 1'b1); expect_out("clr_wins", 0, 4, 1, 0, 0);
        cyc(1'b1, 2'b01, 1'b0); expect_out("reinit", 1, 4, 1, 0, 0);

        // clr_err outside FAULT has no effect on a normal up step.
        cyc(1'b1, 2'b11, 1'b1); expect_out("clr_ign", 2, 5, 1, 1, 0);

        // Walk down to 0, then wrap below zero and back.
        cyc(1'b1, 2'b01, 1'b0); expect_out("w4", 1, 4, 0, 1, 0);
        cyc(1'b1, 2'b00, 1'b0); expect_out("w3", 0, 3, 0, 1, 0);
        cyc(1'b1, 2'b10, 1'b0); expect_out("w2", 3, 2, 0, 1, 0);
        cyc(1'b1, 2'b11, 1'b0); expect_out("w1", 2, 1, 0, 1, 0);
        cyc(1'b1, 2'b01, 1'b0); expect_out("w0", 1, 0, 0, 1, 0);
        cyc(1'b1, 2'b00, 1'b0); expect_out("wrap_dn", 0, 255, 0, 1, 0);
        cyc(1'b1, 2'b01, 1'b0); expect_out("wrap_up", 1, 0, 1, 1, 0);
        cyc(1'b1, 2'b00, 1'b0); expect_out("wrap_dn2", 0, 255, 0, 1, 0);

        // Count up to 7, then reset between edges.
        cyc(1'b1, 2'b01, 1'b0); expect_out("r0", 1, 0, 1, 1, 0);
        cyc(1'b1, 2'b11, 1'b0); expect_out("r1", 2, 1, 1, 1, 0);
        cyc(1'b1, 2'b10, 1'b0); expect_out("r2", 3, 2, 1, 1, 0);
        cyc(1'b1, 2'b00, 1'b0); expect_out("r3", 0, 3, 1, 1, 0);
        cyc(1'b1, 2'b01, 1'b0); expect_out("r4", 1, 4, 1, 1, 0);
        cyc(1'b1, 2'b11, 1'b0); expect_out("r5", 2, 5, 1, 1, 0);
        cyc(1'b1, 2'b10, 1'b0); expect_out("r6", 3, 6, 1, 1, 0);
        cyc(1'b1, 2'b00, 1'b0); expect_out("r7", 0, 7, 1, 1, 0);

        #2 rst = 1'b0;
        #1 expect_out("async_rst", 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // 10 would be a down step from the old reference; after reset it only
        // becomes the new reference.
        cyc(1'b1, 2'b10, 1'b0); expect_out("post_rst", 3, 0, 1, 0, 0);
        cyc(1'b1, 2'b11, 1'b0); expect_out("post_dn", 2, 255, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
